// File: rtl/hpu_pkg.sv
// Shared types and widths for the HPU local-memory DMA path.
package hpu_pkg;

  localparam int LM_BEAT_WTH   = 256;
  localparam int LM_BADDR_WTH  = 18;
  localparam int LMDMA_LEN_WTH = 8;
  localparam int LM_BEAT_BYTES = 32;

  typedef struct packed {
    logic                     wr;
    logic [LM_BADDR_WTH-1:0]  addr;
    logic [LMDMA_LEN_WTH-1:0] len;
  } lmdma_cmd_t;

  typedef enum logic [1:0] {
    LMDMA_IDLE,
    LMDMA_RD,
    LMDMA_RD_DRAIN,
    LMDMA_WR
  } lmdma_state_e;

  function automatic logic [LM_BADDR_WTH-1:0] lm_beat_align(input logic [LM_BADDR_WTH-1:0] a);
    return {a[LM_BADDR_WTH-1:5], 5'b0};
  endfunction

endpackage

// File: rtl/hpu_lmdma_rdfifo.sv
// Read skid FIFO: registered storage, a pushed entry becomes visible the next cycle.
module hpu_lmdma_rdfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 257
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             din_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_push = push_i && (cnt_q != CW'(DEPTH));
    do_pop  = pop_i && (cnt_q != '0);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = din_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (do_pop) rptr_d = ptr_inc(rptr_q);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage needs no reset; the count gates its visibility.
  always_ff @(posedge clk_i) mem_q <= mem_d;

  assign dout_o  = mem_q[rptr_q];
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/hpu_lmdma_ctrl.sv
// Burst controller: one command becomes per-beat local-memory reads or writes.
// States: IDLE wait cmd | RD issue reads | RD_DRAIN wait last pop | WR stream writes.
module hpu_lmdma_ctrl
  import hpu_pkg::*;
#(
  parameter int FIFO_DEP = 4,
  parameter int LEN_WTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_vld_i,
  output logic                     cmd_rdy_o,
  input  logic                     cmd_wr_i,
  input  logic [LM_BADDR_WTH-1:0]  cmd_addr_i,
  input  logic [LEN_WTH-1:0]       cmd_len_i,
  input  logic                     wdat_vld_i,
  output logic                     wdat_rdy_o,
  input  logic [LM_BEAT_WTH-1:0]   wdat_i,
  input  logic [7:0]               wstrb_i,
  output logic                     rdat_vld_o,
  input  logic                     rdat_rdy_i,
  output logic [LM_BEAT_WTH-1:0]   rdat_o,
  output logic                     rdat_last_o,
  output logic                     done_o,
  output logic                     mem_re_o,
  output logic [LM_BADDR_WTH-1:0]  mem_raddr_o,
  input  logic [LM_BEAT_WTH-1:0]   mem_rdata_i,
  input  logic                     mem_rdata_act_i,
  output logic                     mem_we_o,
  output logic [LM_BADDR_WTH-1:0]  mem_waddr_o,
  output logic [LM_BEAT_WTH-1:0]   mem_wdata_o,
  output logic [7:0]               mem_wstrb_o
);
  localparam int             CW    = $clog2(FIFO_DEP + 1);
  localparam logic [CW:0]    DEP_C = (CW + 1)'(FIFO_DEP);

  lmdma_state_e             state_q, state_d;
  logic [LM_BADDR_WTH-1:0]  addr_q, addr_d;
  logic [LEN_WTH-1:0]       remain_q, remain_d;
  logic [CW-1:0]            inflight_q, inflight_d;
  lmdma_cmd_t               cmd;
  logic [CW-1:0]            fifo_cnt;
  logic                     fifo_full, fifo_empty;
  logic [LM_BEAT_WTH:0]     fifo_dout;
  logic                     credit_ok, push_last, rd_pop;

  assign cmd = '{wr: cmd_wr_i, addr: lm_beat_align(cmd_addr_i), len: LMDMA_LEN_WTH'(cmd_len_i)};

  // Reserve a FIFO slot for every read in the memory pipeline before issuing another.
  assign credit_ok = (({1'b0, inflight_q} + {1'b0, fifo_cnt}) < DEP_C) && !fifo_full;
  assign push_last = (state_q == LMDMA_RD_DRAIN) && (inflight_q == CW'(1));
  assign rd_pop    = !fifo_empty && rdat_rdy_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    cmd_rdy_o  = 1'b0;
    wdat_rdy_o = 1'b0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      LMDMA_IDLE: begin
        cmd_rdy_o = 1'b1;
        if (cmd_vld_i) begin
          addr_d   = cmd.addr;
          remain_d = LEN_WTH'(cmd.len);
          state_d  = cmd.wr ? LMDMA_WR : LMDMA_RD;
        end
      end
      LMDMA_RD: begin
        if (credit_ok) begin
          mem_re_o = 1'b1;
          addr_d   = addr_q + LM_BADDR_WTH'(LM_BEAT_BYTES);
          remain_d = remain_q - LEN_WTH'(1);
          if (remain_q == '0) state_d = LMDMA_RD_DRAIN;
        end
      end
      LMDMA_RD_DRAIN: begin
        if (rd_pop && fifo_dout[LM_BEAT_WTH] && (inflight_q == '0)) begin
          done_o  = 1'b1;
          state_d = LMDMA_IDLE;
        end
      end
      LMDMA_WR: begin
        wdat_rdy_o = 1'b1;
        if (wdat_vld_i) begin
          mem_we_o = 1'b1;
          addr_d   = addr_q + LM_BADDR_WTH'(LM_BEAT_BYTES);
          remain_d = remain_q - LEN_WTH'(1);
          if (remain_q == '0) begin
            done_o  = 1'b1;
            state_d = LMDMA_IDLE;
          end
        end
      end
      default: state_d = LMDMA_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (mem_re_o && !mem_rdata_act_i)      inflight_d = inflight_q + CW'(1);
    else if (!mem_re_o && mem_rdata_act_i) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= LMDMA_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
    end
  end

  hpu_lmdma_rdfifo #(
    .DEPTH (FIFO_DEP),
    .WIDTH (LM_BEAT_WTH + 1)
  ) u_rdfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (mem_rdata_act_i),
    .din_i   ({push_last, mem_rdata_i}),
    .pop_i   (rd_pop),
    .dout_o  (fifo_dout),
    .cnt_o   (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rdat_vld_o  = !fifo_empty;
  assign rdat_o      = fifo_empty ? '0 : fifo_dout[LM_BEAT_WTH-1:0];
  assign rdat_last_o = !fifo_empty && fifo_dout[LM_BEAT_WTH];
  assign mem_raddr_o = addr_q;
  assign mem_waddr_o = addr_q;
  assign mem_wdata_o = mem_we_o ? wdat_i : '0;
  assign mem_wstrb_o = mem_we_o ? wstrb_i : '0;

endmodule

// File: tb/tb_hpu_lmdma_ctrl.sv
// Bench for hpu_lmdma_ctrl: 2-cycle memory model, event logs, per-scenario checks.
module tb_hpu_lmdma_ctrl;
  import hpu_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cmd_vld_i = 1'b0, cmd_rdy_o, cmd_wr_i = 1'b0;
  logic [17:0]  cmd_addr_i = '0;
  logic [7:0]   cmd_len_i = '0;
  logic         wdat_vld_i = 1'b0, wdat_rdy_o;
  logic [255:0] wdat_i = '0;
  logic [7:0]   wstrb_i = '0;
  logic         rdat_vld_o, rdat_rdy_i = 1'b0, rdat_last_o, done_o;
  logic [255:0] rdat_o;
  logic         mem_re_o, mem_rdata_act_i, mem_we_o;
  logic [17:0]  mem_raddr_o, mem_waddr_o;
  logic [255:0] mem_rdata_i, mem_wdata_o;
  logic [7:0]   mem_wstrb_o;

  hpu_lmdma_ctrl #(.FIFO_DEP(4), .LEN_WTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdat_vld_i(wdat_vld_i), .wdat_rdy_o(wdat_rdy_o), .wdat_i(wdat_i), .wstrb_i(wstrb_i),
    .rdat_vld_o(rdat_vld_o), .rdat_rdy_i(rdat_rdy_i), .rdat_o(rdat_o),
    .rdat_last_o(rdat_last_o), .done_o(done_o),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
    .mem_rdata_i(mem_rdata_i), .mem_rdata_act_i(mem_rdata_act_i),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model: data is a salted function of the beat address, returned 2 cycles later.
  logic [31:0]  salt = 32'h0;
  logic [1:0]   act_p;
  logic [255:0] d_p0, d_p1;

  function automatic logic [255:0] memf(input logic [17:0] a);
    logic [31:0] w;
    w = {14'd0, a} ^ salt;
    return {8{w}};
  endfunction

  function automatic logic [17:0] exp_addr(input logic [17:0] base, input int i);
    int unsigned v;
    v = (int'(base) / 32) * 32 + 32 * i;
    return 18'(v % 262144);
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      act_p <= '0;
      d_p0  <= '0;
      d_p1  <= '0;
    end else begin
      act_p <= {act_p[0], mem_re_o};
      d_p0  <= mem_re_o ? memf(mem_raddr_o) : '0;
      d_p1  <= d_p0;
    end
  end
  assign mem_rdata_act_i = act_p[1];
  assign mem_rdata_i     = d_p1;

  // Event logs sampled mid-cycle.
  int           re_cyc[$], we_cyc[$], pop_cyc[$], done_cyc[$], acc_cyc[$];
  logic [17:0]  re_adr[$], we_adr[$];
  logic [255:0] we_dat[$], pop_dat[$];
  logic [7:0]   we_stb[$];
  logic         pop_last[$];
  int           vld_seen = 0;
  bit           both_ever = 1'b0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (mem_re_o) begin re_cyc.push_back(cyc); re_adr.push_back(mem_raddr_o); end
      if (mem_we_o) begin
        we_cyc.push_back(cyc); we_adr.push_back(mem_waddr_o);
        we_dat.push_back(mem_wdata_o); we_stb.push_back(mem_wstrb_o);
      end
      if (rdat_vld_o && rdat_rdy_i) begin
        pop_cyc.push_back(cyc); pop_dat.push_back(rdat_o); pop_last.push_back(rdat_last_o);
      end
      if (done_o) done_cyc.push_back(cyc);
      if (cmd_vld_i && cmd_rdy_o) acc_cyc.push_back(cyc);
      if (rdat_vld_o) vld_seen++;
      if (mem_re_o && mem_we_o) both_ever = 1'b1;
    end
  end

  task automatic clear_log();
    re_cyc.delete(); re_adr.delete(); we_cyc.delete(); we_adr.delete();
    we_dat.delete(); we_stb.delete(); pop_cyc.delete(); pop_dat.delete();
    pop_last.delete(); done_cyc.delete(); acc_cyc.delete(); vld_seen = 0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [17:0] a, input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    cmd_vld_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = a; cmd_len_i = len;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk_i); ok = cmd_rdy_o;
      tick();
    end
    cmd_vld_i = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_rdy_o never seen within 60 cycles (required 1)");
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!cmd_rdy_o && n < bound) begin @(negedge clk_i); n++; end
    if (!cmd_rdy_o) begin
      checks++; errors++;
      $display("FAIL %s_timeout: cmd_rdy_o=0 after %0d cycles, required 1", name, bound);
    end
    tick();
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    obs = {cmd_rdy_o, wdat_rdy_o, rdat_vld_o, rdat_last_o, done_o, mem_re_o, mem_we_o,
           |rdat_o, |mem_raddr_o, |mem_waddr_o, |mem_wdata_o, |mem_wstrb_o};
    checks++;
    if (obs !== 12'h800) begin errors++; $display("FAIL reset_outputs: got %03h required 800", obs); end
    tick(); rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (cmd_rdy_o !== 1'b1 || mem_re_o !== 1'b0 || rdat_vld_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: rdy=%b re=%b vld=%b required 1 0 0", cmd_rdy_o, mem_re_o, rdat_vld_o);
    end
    tick();
  endtask

  task automatic test_read_basic();
    int a;
    salt = $urandom; clear_log(); rdat_rdy_i = 1'b1;
    issue_cmd(1'b0, 18'h00100, 8'd3);
    wait_idle("rd_basic", 40);
    a = (acc_cyc.size() > 0) ? acc_cyc[0] : -100;
    checks++;
    if (re_cyc.size() != 4) begin errors++; $display("FAIL rd_basic_re_count: got %0d required 4", re_cyc.size()); end
    for (int i = 0; i < 4 && i < re_cyc.size(); i++) begin
      checks++;
      if (re_adr[i] !== exp_addr(18'h00100, i) || re_cyc[i] != a + 1 + i) begin
        errors++; $display("FAIL rd_basic_re%0d: addr %05h cyc %0d required %05h cyc %0d",
                           i, re_adr[i], re_cyc[i], exp_addr(18'h00100, i), a + 1 + i);
      end
    end
    checks++;
    if (pop_cyc.size() != 4) begin errors++; $display("FAIL rd_basic_pop_count: got %0d required 4", pop_cyc.size()); end
    for (int i = 0; i < 4 && i < pop_cyc.size(); i++) begin
      checks++;
      if (pop_dat[i] !== memf(exp_addr(18'h00100, i)) || pop_last[i] !== (i == 3) || pop_cyc[i] != a + 4 + i) begin
        errors++; $display("FAIL rd_basic_pop%0d: data %h last %b cyc %0d required data %h last %b cyc %0d",
                           i, pop_dat[i][31:0], pop_last[i], pop_cyc[i], memf(exp_addr(18'h00100, i)) >> 224, (i == 3), a + 4 + i);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != a + 7) begin
      errors++; $display("FAIL rd_basic_done: count %0d required 1 at cyc %0d", done_cyc.size(), a + 7);
    end
  endtask

  task automatic test_read_stall();
    logic [17:0] base;
    int rel;
    salt = $urandom; clear_log(); rdat_rdy_i = 1'b0;
    base = 18'($urandom);
    issue_cmd(1'b0, base, 8'd15);
    repeat (20) tick();
    checks++;
    if (re_cyc.size() != 4) begin errors++; $display("FAIL rd_stall_credit: %0d reads issued, required 4", re_cyc.size()); end
    rel = cyc;
    rdat_rdy_i = 1'b1;
    wait_idle("rd_stall", 200);
    checks++;
    if (re_cyc.size() != 16 || pop_cyc.size() != 16) begin
      errors++; $display("FAIL rd_stall_counts: reads %0d pops %0d required 16 16", re_cyc.size(), pop_cyc.size());
    end
    for (int i = 0; i < 16 && i < pop_cyc.size(); i++) begin
      checks++;
      if (pop_dat[i] !== memf(exp_addr(base, i)) || pop_last[i] !== (i == 15) || pop_cyc[i] < rel) begin
        errors++; $display("FAIL rd_stall_pop%0d: data %h last %b cyc %0d required data %h last %b cyc>=%0d",
                           i, pop_dat[i][31:0], pop_last[i], pop_cyc[i], memf(exp_addr(base, i)) >> 224, (i == 15), rel);
      end
    end
    checks++;
    if (done_cyc.size() != 1) begin errors++; $display("FAIL rd_stall_done: count %0d required 1", done_cyc.size()); end
  endtask

  task automatic test_write_wrap();
    logic [255:0] d[$];
    int vc[$];
    clear_log();
    issue_cmd(1'b1, 18'h3FFC0, 8'd2);
    for (int i = 0; i < 3; i++) begin
      wdat_vld_i = 1'b1; wdat_i = {8{$urandom}}; wstrb_i = 8'hff;
      d.push_back(wdat_i); vc.push_back(cyc);
      tick();
    end
    wdat_vld_i = 1'b0;
    wait_idle("wr_wrap", 20);
    checks++;
    if (we_cyc.size() != 3) begin errors++; $display("FAIL wr_wrap_count: got %0d required 3", we_cyc.size()); end
    for (int i = 0; i < 3 && i < we_cyc.size(); i++) begin
      checks++;
      if (we_adr[i] !== exp_addr(18'h3FFC0, i) || we_dat[i] !== d[i] || we_stb[i] !== 8'hff || we_cyc[i] != vc[i]) begin
        errors++; $display("FAIL wr_wrap_beat%0d: addr %05h strb %02h cyc %0d required %05h ff %0d",
                           i, we_adr[i], we_stb[i], we_cyc[i], exp_addr(18'h3FFC0, i), vc[i]);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != vc[2]) begin
      errors++; $display("FAIL wr_wrap_done: count %0d required 1 at cyc %0d", done_cyc.size(), vc[2]);
    end
  endtask

  task automatic test_write_gapped();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [255:0] d[$];
    logic [7:0]   s[$];
    int vc[$];
    logic [17:0] base;
    clear_log();
    wdat_vld_i = 1'b1; wdat_i = {8{$urandom}};
    @(negedge clk_i);
    checks++;
    if (wdat_rdy_o !== 1'b0 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL idle_wdat: rdy %b we %b required 0 0", wdat_rdy_o, mem_we_o);
    end
    tick(); wdat_vld_i = 1'b0;
    base = 18'($urandom);
    issue_cmd(1'b1, base, 8'd1);
    for (int i = 0; i < 4; i++) begin
      wdat_vld_i = pat[i]; wdat_i = {8{$urandom}}; wstrb_i = 8'($urandom);
      if (pat[i]) begin d.push_back(wdat_i); s.push_back(wstrb_i); vc.push_back(cyc); end
      tick();
    end
    wdat_vld_i = 1'b0;
    wait_idle("wr_gap", 20);
    checks++;
    if (we_cyc.size() != 2) begin errors++; $display("FAIL wr_gap_count: got %0d required 2", we_cyc.size()); end
    for (int i = 0; i < 2 && i < we_cyc.size(); i++) begin
      checks++;
      if (we_adr[i] !== exp_addr(base, i) || we_dat[i] !== d[i] || we_stb[i] !== s[i] || we_cyc[i] != vc[i]) begin
        errors++; $display("FAIL wr_gap_beat%0d: addr %05h strb %02h cyc %0d required %05h %02h %0d",
                           i, we_adr[i], we_stb[i], we_cyc[i], exp_addr(base, i), s[i], vc[i]);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != vc[1]) begin
      errors++; $display("FAIL wr_gap_done: count %0d required 1 at cyc %0d", done_cyc.size(), vc[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] obs;
    salt = $urandom; clear_log(); rdat_rdy_i = 1'b0;
    issue_cmd(1'b0, 18'($urandom), 8'd7);
    tick(); tick();
    #1 rst_i = 1'b0;
    #1;
    obs = {cmd_rdy_o, wdat_rdy_o, rdat_vld_o, rdat_last_o, done_o, mem_re_o, mem_we_o,
           |rdat_o, |mem_raddr_o, |mem_waddr_o, |mem_wdata_o, |mem_wstrb_o};
    checks++;
    if (obs !== 12'h800) begin errors++; $display("FAIL reset_mid_outputs: got %03h required 800", obs); end
    repeat (2) tick();
    rst_i = 1'b1; rdat_rdy_i = 1'b1;
    clear_log();
    repeat (12) tick();
    checks++;
    if (vld_seen != 0 || re_cyc.size() != 0 || done_cyc.size() != 0) begin
      errors++; $display("FAIL reset_mid_quiet: vld %0d reads %0d done %0d required 0 0 0", vld_seen, re_cyc.size(), done_cyc.size());
    end
    checks++;
    if (cmd_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_mid_idle: cmd_rdy_o %b required 1", cmd_rdy_o); end
  endtask

  task automatic test_back_to_back();
    logic [17:0]  ra, wa;
    logic [255:0] wd;
    int wc;
    salt = $urandom; clear_log(); rdat_rdy_i = 1'b1;
    ra = 18'($urandom); wa = 18'($urandom);
    issue_cmd(1'b0, ra, 8'd0);
    issue_cmd(1'b1, wa, 8'd0);
    wdat_vld_i = 1'b1; wdat_i = {8{$urandom}}; wstrb_i = 8'($urandom); wd = wdat_i; wc = cyc;
    tick();
    wdat_vld_i = 1'b0;
    wait_idle("b2b", 20);
    checks++;
    if (acc_cyc.size() != 2 || done_cyc.size() != 2 || acc_cyc[1] != done_cyc[0] + 1) begin
      errors++; $display("FAIL b2b_accept: accepts %0d dones %0d, second accept must follow first done by 1 cycle",
                         acc_cyc.size(), done_cyc.size());
    end
    checks++;
    if (pop_cyc.size() != 1 || pop_dat[0] !== memf(exp_addr(ra, 0)) || pop_last[0] !== 1'b1 ||
        done_cyc.size() < 1 || done_cyc[0] != pop_cyc[0]) begin
      errors++; $display("FAIL b2b_read: pops %0d required 1 beat with last and done on pop", pop_cyc.size());
    end
    checks++;
    if (we_cyc.size() != 1 || we_adr[0] !== exp_addr(wa, 0) || we_dat[0] !== wd || we_cyc[0] != wc ||
        done_cyc.size() < 2 || done_cyc[1] != wc) begin
      errors++; $display("FAIL b2b_write: writes %0d required 1 at %05h cyc %0d with done", we_cyc.size(), exp_addr(wa, 0), wc);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic         wr;
      logic [17:0]  base;
      int           len, n, offered;
      bit           idle;
      logic [255:0] d[$];
      logic [7:0]   s[$];
      int           vc[$];
      wr = 1'($urandom_range(0, 1)); base = 18'($urandom); len = int'($urandom_range(0, 20));
      salt = $urandom; clear_log();
      issue_cmd(wr, base, 8'(len));
      if (!wr) begin
        idle = 1'b0;
        for (n = 0; n < 500 && !idle; n++) begin
          rdat_rdy_i = 1'($urandom_range(0, 1));
          @(negedge clk_i); idle = cmd_rdy_o;
          tick();
        end
        rdat_rdy_i = 1'b1;
        checks++;
        if (!idle || re_cyc.size() != len + 1 || pop_cyc.size() != len + 1 || done_cyc.size() != 1) begin
          errors++; $display("FAIL rand%0d_rd_counts: reads %0d pops %0d dones %0d required %0d %0d 1",
                             it, re_cyc.size(), pop_cyc.size(), done_cyc.size(), len + 1, len + 1);
        end
        for (int i = 0; i <= len && i < pop_cyc.size(); i++) begin
          checks++;
          if (pop_dat[i] !== memf(exp_addr(base, i)) || pop_last[i] !== (i == len)) begin
            errors++; $display("FAIL rand%0d_rd_pop%0d: data %h last %b required %h %b",
                               it, i, pop_dat[i][31:0], pop_last[i], memf(exp_addr(base, i)) >> 224, (i == len));
          end
        end
      end else begin
        offered = 0;
        for (n = 0; n < 500 && offered <= len; n++) begin
          wdat_vld_i = ($urandom_range(0, 2) != 0); wdat_i = {8{$urandom}}; wstrb_i = 8'($urandom);
          if (wdat_vld_i) begin d.push_back(wdat_i); s.push_back(wstrb_i); vc.push_back(cyc); offered++; end
          tick();
        end
        wdat_vld_i = 1'b0;
        wait_idle("rand_wr", 20);
        checks++;
        if (we_cyc.size() != len + 1 || done_cyc.size() != 1 || done_cyc[0] != vc[len]) begin
          errors++; $display("FAIL rand%0d_wr_counts: writes %0d dones %0d required %0d 1", it, we_cyc.size(), done_cyc.size(), len + 1);
        end
        for (int i = 0; i <= len && i < we_cyc.size(); i++) begin
          checks++;
          if (we_adr[i] !== exp_addr(base, i) || we_dat[i] !== d[i] || we_stb[i] !== s[i] || we_cyc[i] != vc[i]) begin
            errors++; $display("FAIL rand%0d_wr_beat%0d: addr %05h cyc %0d required %05h %0d",
                               it, i, we_adr[i], we_cyc[i], exp_addr(base, i), vc[i]);
          end
        end
      end
    end
    checks++;
    if (both_ever) begin errors++; $display("FAIL re_we_exclusive: mem_re_o and mem_we_o seen together, required never"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_basic();
    test_read_stall();
    test_write_wrap();
    test_write_gapped();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
